// File: rtl/morse_letter_decoder.sv
`default_nettype none
// ============================================================================
// Module      : morse_letter_decoder
// Description : Per-tick Morse sampler. It classifies marks as dot or dash,
//               detects the inter-letter gap and emits the letter index Q..X
//               (0..7) with a one-cycle valid or error strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module morse_letter_decoder #(
    parameter int LETTER_GAP = 3,
    parameter int RUN_W      = 3
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       tick,
    input  logic       morse_in,
    output logic [2:0] letter,
    output logic       letter_valid,
    output logic       error,
    output logic [2:0] sym_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MARK  = 2'd1,
        S_SPACE = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    localparam logic [RUN_W-1:0] c_RUN_MAX   = '1;
    localparam logic [RUN_W-1:0] c_RUN_ONE   = RUN_W'(1);
    localparam logic [RUN_W-1:0] c_RUN_DASH  = RUN_W'(2);
    localparam logic [RUN_W-1:0] c_LONG_MARK = RUN_W'(3);
    localparam logic [RUN_W-1:0] c_GAP       = RUN_W'(LETTER_GAP);

    state_t           r_state,   w_state_nxt;
    logic [RUN_W-1:0] r_run_cnt, w_run_nxt;
    logic [3:0]       r_pattern, w_pattern_nxt;
    logic [2:0]       r_sym_cnt, w_sym_nxt;
    logic [2:0]       r_letter,  w_letter_nxt;
    logic             r_valid,   w_valid_nxt;
    logic             r_error,   w_error_nxt;
    logic [RUN_W-1:0] w_run_inc;
    logic             w_hit;
    logic [2:0]       w_idx;

    assign w_run_inc = (r_run_cnt == c_RUN_MAX) ? r_run_cnt : r_run_cnt + c_RUN_ONE;

    // Letter table; newest symbol at the LSB, 1 = dash.
    always_comb begin
        w_hit = 1'b0;
        w_idx = 3'd0;
        case (r_sym_cnt)
            3'd1: begin
                if (r_pattern[0]) begin
                    w_hit = 1'b1;
                    w_idx = 3'd3;
                end
            end
            3'd3: begin
                case (r_pattern[2:0])
                    3'b010:  begin w_hit = 1'b1; w_idx = 3'd1; end
                    3'b000:  begin w_hit = 1'b1; w_idx = 3'd2; end
                    3'b001:  begin w_hit = 1'b1; w_idx = 3'd4; end
                    3'b011:  begin w_hit = 1'b1; w_idx = 3'd6; end
                    default: ;
                endcase
            end
            3'd4: begin
                case (r_pattern)
                    4'b1101: begin w_hit = 1'b1; w_idx = 3'd0; end
                    4'b0001: begin w_hit = 1'b1; w_idx = 3'd5; end
                    4'b1001: begin w_hit = 1'b1; w_idx = 3'd7; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_run_nxt     = r_run_cnt;
        w_pattern_nxt = r_pattern;
        w_sym_nxt     = r_sym_cnt;
        w_letter_nxt  = r_letter;
        w_valid_nxt   = 1'b0;
        w_error_nxt   = 1'b0;
        if (tick) begin
            case (r_state)
                S_IDLE: begin
                    if (morse_in) begin
                        w_state_nxt = S_MARK;
                        w_run_nxt   = c_RUN_ONE;
                    end
                end
                S_MARK: begin
                    if (morse_in) begin
                        if (w_run_inc >= c_LONG_MARK) begin
                            w_state_nxt = S_ERR;
                            w_run_nxt   = '0;
                            w_error_nxt = 1'b1;
                        end else begin
                            w_run_nxt = w_run_inc;
                        end
                    end else if (r_sym_cnt == 3'd4) begin
                        w_state_nxt = S_ERR;
                        w_run_nxt   = '0;
                        w_error_nxt = 1'b1;
                    end else begin
                        w_pattern_nxt = {r_pattern[2:0], (r_run_cnt == c_RUN_DASH)};
                        w_sym_nxt     = r_sym_cnt + 3'd1;
                        w_state_nxt   = S_SPACE;
                        w_run_nxt     = c_RUN_ONE;
                    end
                end
                S_SPACE: begin
                    if (morse_in) begin
                        w_state_nxt = S_MARK;
                        w_run_nxt   = c_RUN_ONE;
                    end else begin
                        w_run_nxt = w_run_inc;
                        if (w_run_inc >= c_GAP) begin
                            if (w_hit) begin
                                w_letter_nxt = w_idx;
                                w_valid_nxt  = 1'b1;
                            end else begin
                                w_error_nxt  = 1'b1;
                            end
                            w_pattern_nxt = '0;
                            w_sym_nxt     = '0;
                            w_run_nxt     = '0;
                            w_state_nxt   = S_IDLE;
                        end
                    end
                end
                S_ERR: begin
                    // Any high restarts the quiet-period count.
                    if (morse_in) begin
                        w_run_nxt = '0;
                    end else begin
                        w_run_nxt = w_run_inc;
                        if (w_run_inc >= c_GAP) begin
                            w_pattern_nxt = '0;
                            w_sym_nxt     = '0;
                            w_run_nxt     = '0;
                            w_state_nxt   = S_IDLE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_run_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_run_cnt <= '0;
            r_pattern <= '0;
            r_sym_cnt <= '0;
            r_letter  <= '0;
            r_valid   <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_run_cnt <= w_run_nxt;
            r_pattern <= w_pattern_nxt;
            r_sym_cnt <= w_sym_nxt;
            r_letter  <= w_letter_nxt;
            r_valid   <= w_valid_nxt;
            r_error   <= w_error_nxt;
        end
    end

    assign letter       = r_letter;
    assign letter_valid = r_valid;
    assign error        = r_error;
    assign sym_count    = r_sym_cnt;

endmodule
`default_nettype wire
